dual_port_mem: RTL and testbench
================================

DUAL_PORT_MEM -- requirements
Module: dual_port_mem

Interface
REQ-001 The module SHALL have parameter SIZE, default 4096, meaning memory size in bytes (power of two).
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning word width in bits (32 or 64).
REQ-003 The module SHALL have parameter LATENCY, default 1, meaning the number of cycles from request accept to response (1..4).
REQ-004 The module SHALL have parameter WRITE_FIRST, default 0, meaning port B returns new data on a same-word collision when 1 and old data when 0.
REQ-005 The module SHALL derive localparam ADDR_WIDTH = $clog2(SIZE) and NB = DATA_WIDTH/8.
REQ-006 The module SHALL have one clock and a synchronous, active-high reset: clk (input, 1 bit, clock, all state on posedge) and rst (input, 1 bit, synchronous active-high reset).
REQ-007 Port A SHALL have the following signals:
- a_req (input, 1): request.
- a_ready (output, 1): request accepted this cycle when high together with a_req.
- a_addr (input, ADDR_WIDTH): byte address.
- a_we (input, 1): write.
- a_wstrb (input, NB): byte-lane enables.
- a_wdata (input, DATA_WIDTH): write data.
- a_rvalid (output, 1): response valid.
- a_rdata (output, DATA_WIDTH): response data.
- a_err (output, 1): misaligned access.
REQ-008 Port B SHALL be read-only, with the following signals:
- b_req (input, 1).
- b_ready (output, 1).
- b_addr (input, ADDR_WIDTH).
- b_rvalid (output, 1).
- b_rdata (output, DATA_WIDTH).
- b_err (output, 1).

Function
REQ-009 a_ready and b_ready SHALL equal !rst; a request is accepted on a posedge where req && ready.
REQ-010 The word index SHALL be addr[ADDR_WIDTH-1:$clog2(NB)]; addresses are inherently wrapped modulo SIZE.
REQ-011 A request with addr[$clog2(NB)-1:0] != 0 SHALL be misaligned: no memory change, response err=1 and rdata=0.
REQ-012 An aligned write SHALL update exactly the byte lanes with a_wstrb[i]=1 at the accept edge; lanes with strobe 0 SHALL be unchanged.
REQ-013 A write with a_wstrb=0 SHALL be a legal no-op that still produces a response.
REQ-014 Every accepted request SHALL produce exactly one response, with rvalid high for one cycle exactly LATENCY cycles after the accept edge.
REQ-015 Responses on each port SHALL be returned in order, with throughput of one request per cycle per port and no bubbles.
REQ-016 A read response SHALL carry the word contents as of the accept edge, excluding that same edge's writes except as given in REQ-018.
REQ-017 A write response SHALL carry the word contents before the write (read-before-write) with err=0.
REQ-018 When port A writes and port B reads the same word on the same edge, b_rdata SHALL be the pre-write word if WRITE_FIRST=0, or the strobe-merged post-write word if WRITE_FIRST=1.
REQ-019 When port A writes and reads back the same word on consecutive requests, the second request SHALL see the first write.
REQ-020 While rvalid=0, rdata and err SHALL hold 0.
REQ-021 The response path SHALL be a LATENCY-deep shift pipeline per port carrying (valid, err, data).

Reset
REQ-022 While rst=1 on a posedge, the module SHALL set a_rvalid, b_rvalid, a_err, b_err = 0 and a_rdata, b_rdata = 0, and clear all pipeline stages.
REQ-023 Requests presented while rst=1 SHALL NOT be accepted, SHALL NOT write memory, and SHALL NOT produce a response.
REQ-024 A reset asserted mid-operation SHALL discard in-flight responses; their writes already committed at the accept edge SHALL remain.
REQ-025 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-026 The bench SHALL cover this scenario (LATENCY=1): A writes 0xDEADBEEF at addr 0x10 with wstrb=4'hF, then B reads 0x10 -> b_rvalid is asserted one cycle after the B accept with b_rdata=0xDEADBEEF.
REQ-027 The bench SHALL cover this scenario: word 0x10=0xDEADBEEF, A writes 0x000000AA with wstrb=4'h1, then A reads 0x10 -> a_rdata=0xDEADBEAA, and the write response returns 0xDEADBEEF.
REQ-028 The bench SHALL cover this scenario: A reads addr 0x13 -> a_rvalid=1, a_err=1, a_rdata=0, and memory is unchanged.
REQ-029 The bench SHALL cover this scenario: same-edge A write 0x11111111 and B read at 0x20 (old value 0x0) -> b_rdata=0x0 with WRITE_FIRST=0 and 0x11111111 with WRITE_FIRST=1.
REQ-030 The bench SHALL cover this scenario (LATENCY=3): back-to-back B reads of 0x0, 0x4 and 0x8 -> three consecutive rvalid cycles starting 3 cycles after the first accept, in order.
REQ-031 The bench SHALL cover this scenario (LATENCY=3): rst is asserted one cycle after two accepted reads -> no rvalid is emitted, all outputs are 0, and ready is 0 while rst=1.

Source files
------------

// File: rtl/dual_port_mem.sv
`default_nettype none
// ============================================================================
// Module      : dual_port_mem
// Description : Byte-addressed RAM with a read/write port A and a read-only
//               port B, each answering through a fixed-latency pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module dual_port_mem #(
    parameter int SIZE        = 4096,
    parameter int DATA_WIDTH  = 32,
    parameter int LATENCY     = 1,
    parameter bit WRITE_FIRST = 1'b0,
    localparam int ADDR_WIDTH = $clog2(SIZE),
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // port A
    input  logic                  a_req,
    output logic                  a_ready,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_we,
    input  logic [NB-1:0]         a_wstrb,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    output logic                  a_err,
    // port B
    input  logic                  b_req,
    output logic                  b_ready,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  b_err
);

    localparam int c_OFF   = $clog2(NB);
    localparam int c_IW    = ADDR_WIDTH - c_OFF;
    localparam int c_WORDS = SIZE / NB;

    logic [DATA_WIDTH-1:0] r_mem [c_WORDS];

    logic [c_IW-1:0]       w_a_idx;
    logic [c_IW-1:0]       w_b_idx;
    logic [DATA_WIDTH-1:0] w_a_old;
    logic [DATA_WIDTH-1:0] w_b_old;
    logic [DATA_WIDTH-1:0] w_a_merged;
    logic                  w_a_wr;
    logic                  w_collide;
    logic [1:0]            w_acc;
    logic [1:0]            w_mis;
    logic [DATA_WIDTH-1:0] w_rsp [2];

    assign a_ready = !rst;
    assign b_ready = !rst;

    assign w_acc[0] = a_req && !rst;
    assign w_acc[1] = b_req && !rst;
    assign w_mis[0] = |a_addr[c_OFF-1:0];
    assign w_mis[1] = |b_addr[c_OFF-1:0];

    assign w_a_idx = a_addr[ADDR_WIDTH-1:c_OFF];
    assign w_b_idx = b_addr[ADDR_WIDTH-1:c_OFF];
    assign w_a_old = r_mem[w_a_idx];
    assign w_b_old = r_mem[w_b_idx];

    always_comb begin
        w_a_merged = w_a_old;
        for (int i = 0; i < NB; i++) begin
            if (a_wstrb[i]) begin
                w_a_merged[8*i +: 8] = a_wdata[8*i +: 8];
            end
        end
    end

    assign w_a_wr    = w_acc[0] && a_we && !w_mis[0];
    // B sees A's merged word only when configured write-first and both hit one word
    assign w_collide = WRITE_FIRST && w_a_wr && (w_a_idx == w_b_idx);

    assign w_rsp[0] = w_a_old;
    assign w_rsp[1] = w_collide ? w_a_merged : w_b_old;

    // Contents survive reset; rejected requests never reach here since w_acc needs !rst
    always_ff @(posedge clk) begin
        if (w_a_wr) begin
            r_mem[w_a_idx] <= w_a_merged;
        end
    end

    logic [LATENCY-1:0]    r_vld [2];
    logic [LATENCY-1:0]    r_err [2];
    logic [DATA_WIDTH-1:0] r_dat [2][LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < 2; p++) begin
                r_vld[p] <= '0;
                r_err[p] <= '0;
                for (int s = 0; s < LATENCY; s++) begin
                    r_dat[p][s] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_vld[p][0] <= w_acc[p];
                r_err[p][0] <= w_acc[p] && w_mis[p];
                r_dat[p][0] <= (w_acc[p] && !w_mis[p]) ? w_rsp[p] : '0;
                for (int s = 1; s < LATENCY; s++) begin
                    r_vld[p][s] <= r_vld[p][s-1];
                    r_err[p][s] <= r_err[p][s-1];
                    r_dat[p][s] <= r_dat[p][s-1];
                end
            end
        end
    end

    assign a_rvalid = r_vld[0][LATENCY-1];
    assign a_err    = r_err[0][LATENCY-1];
    assign a_rdata  = r_dat[0][LATENCY-1];
    assign b_rvalid = r_vld[1][LATENCY-1];
    assign b_err    = r_err[1][LATENCY-1];
    assign b_rdata  = r_dat[1][LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_dual_port_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_dual_port_mem
// Description : Randomised and directed checks of two dual_port_mem builds
//               (latency 1 read-first, latency 3 write-first) on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dual_port_mem;

    localparam int c_SIZE = 256;
    localparam int c_DW   = 32;
    localparam int c_AW   = 8;
    localparam int c_NW   = c_SIZE / 4;
    localparam int c_NC   = 4096;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            a_req = 1'b0, a_we = 1'b0, b_req = 1'b0;
    logic [c_AW-1:0] a_addr = '0, b_addr = '0;
    logic [3:0]      a_wstrb = '0;
    logic [c_DW-1:0] a_wdata = '0;

    logic [1:0]      a_ready, a_rvalid, a_err, b_ready, b_rvalid, b_err;
    logic [c_DW-1:0] a_rdata [2];
    logic [c_DW-1:0] b_rdata [2];

    dual_port_mem #(.SIZE(c_SIZE), .DATA_WIDTH(c_DW), .LATENCY(1), .WRITE_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_ready(a_ready[0]), .a_addr(a_addr), .a_we(a_we),
        .a_wstrb(a_wstrb), .a_wdata(a_wdata), .a_rvalid(a_rvalid[0]),
        .a_rdata(a_rdata[0]), .a_err(a_err[0]),
        .b_req(b_req), .b_ready(b_ready[0]), .b_addr(b_addr),
        .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]), .b_err(b_err[0])
    );

    dual_port_mem #(.SIZE(c_SIZE), .DATA_WIDTH(c_DW), .LATENCY(3), .WRITE_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_ready(a_ready[1]), .a_addr(a_addr), .a_we(a_we),
        .a_wstrb(a_wstrb), .a_wdata(a_wdata), .a_rvalid(a_rvalid[1]),
        .a_rdata(a_rdata[1]), .a_err(a_err[1]),
        .b_req(b_req), .b_ready(b_ready[1]), .b_addr(b_addr),
        .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]), .b_err(b_err[1])
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    // Reference memory; known[] is clear until a word has been fully written
    logic [31:0] mem   [c_NW];
    bit          known [c_NW];

    // Expected response per build, port (0=A, 1=B) and edge index at which it appears
    bit          ev [2][2][c_NC];
    bit          ee [2][2][c_NC];
    bit          ek [2][2][c_NC];
    logic [31:0] ed [2][2][c_NC];

    function automatic int lat(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got 0x%0h, wanted 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic post(int d, int p, int n, bit err, logic [31:0] data, bit kn);
        int k;
        k = n + lat(d) - 1;
        ev[d][p][k] = 1'b1;
        ee[d][p][k] = err;
        ed[d][p][k] = data;
        ek[d][p][k] = kn;
    endtask

    task automatic model_edge(int n);
        int          ai, bi;
        bit          am, bm, awr, nkn;
        logic [31:0] aold, bold, nw, bdat;
        if (rst) begin
            for (int d = 0; d < 2; d++)
                for (int p = 0; p < 2; p++)
                    for (int k = n; k < n + 4; k++)
                        ev[d][p][k] = 1'b0;
            return;
        end
        ai   = int'(a_addr[7:2]);
        bi   = int'(b_addr[7:2]);
        am   = (a_addr[1:0] != 2'b00);
        bm   = (b_addr[1:0] != 2'b00);
        aold = mem[ai];
        bold = mem[bi];
        nw   = aold;
        for (int i = 0; i < 4; i++)
            if (a_wstrb[i]) nw[8*i +: 8] = a_wdata[8*i +: 8];
        awr = a_req && a_we && !am;
        nkn = known[ai] || (a_wstrb == 4'hF);
        for (int d = 0; d < 2; d++) begin
            if (a_req)
                post(d, 0, n, am, am ? 32'h0 : aold, am || known[ai]);
            if (b_req) begin
                if (d == 1 && awr && ai == bi) post(d, 1, n, bm, bm ? 32'h0 : nw, bm || nkn);
                else                           post(d, 1, n, bm, bm ? 32'h0 : bold, bm || known[bi]);
            end
        end
        if (awr) begin
            mem[ai]   = nw;
            known[ai] = nkn;
        end
    endtask

    task automatic check_outs(int k);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("d%0d.a_ready", d), 64'(a_ready[d]), 64'(!rst));
            check($sformatf("d%0d.b_ready", d), 64'(b_ready[d]), 64'(!rst));
            check($sformatf("d%0d.a_rvalid", d), 64'(a_rvalid[d]), 64'(ev[d][0][k]));
            check($sformatf("d%0d.a_err", d), 64'(a_err[d]), 64'(ev[d][0][k] && ee[d][0][k]));
            if (!ev[d][0][k] || ek[d][0][k])
                check($sformatf("d%0d.a_rdata", d), 64'(a_rdata[d]), ev[d][0][k] ? 64'(ed[d][0][k]) : 64'h0);
            check($sformatf("d%0d.b_rvalid", d), 64'(b_rvalid[d]), 64'(ev[d][1][k]));
            check($sformatf("d%0d.b_err", d), 64'(b_err[d]), 64'(ev[d][1][k] && ee[d][1][k]));
            if (!ev[d][1][k] || ek[d][1][k])
                check($sformatf("d%0d.b_rdata", d), 64'(b_rdata[d]), ev[d][1][k] ? 64'(ed[d][1][k]) : 64'h0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(cyc);
        @(negedge clk);
        check_outs(cyc);
        cyc++;
    endtask

    task automatic drive(bit ar, bit aw, logic [7:0] aa, logic [3:0] st, logic [31:0] wd,
                         bit br, logic [7:0] ba);
        a_req = ar; a_we = aw; a_addr = aa; a_wstrb = st; a_wdata = wd;
        b_req = br; b_addr = ba;
    endtask

    task automatic idle(int n);
        drive(0, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [5:0] vpat;

    initial begin
        // Requests held during reset must be ignored
        rst = 1'b1;
        drive(1, 1, 8'h00, 4'hF, 32'hFFFF_FFFF, 1, 8'h00);
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;

        for (int w = 0; w < c_NW; w++) begin
            drive(1, 1, 8'(w * 4), 4'hF, 32'h0, 0, 8'h0);
            tick();
        end
        idle(3);

        // full write then B read-back
        drive(1, 1, 8'h10, 4'hF, 32'hDEAD_BEEF, 0, 8'h0); tick();
        check("s26_wr_rsp", 64'(a_rdata[0]), 64'h0);
        drive(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h10); tick();
        check("s26_b_rvalid", 64'(b_rvalid[0]), 64'h1);
        check("s26_b_rdata", 64'(b_rdata[0]), 64'hDEAD_BEEF);

        // single-lane write, old word returned, then merged read-back
        drive(1, 1, 8'h10, 4'h1, 32'h0000_00AA, 0, 8'h0); tick();
        check("s27_wr_rsp", 64'(a_rdata[0]), 64'hDEAD_BEEF);
        drive(1, 0, 8'h10, 4'h0, 32'h0, 0, 8'h0); tick();
        check("s27_rd", 64'(a_rdata[0]), 64'hDEAD_BEAA);

        // misaligned accesses leave memory alone
        drive(1, 0, 8'h13, 4'h0, 32'h0, 0, 8'h0); tick();
        check("s28_rvalid", 64'(a_rvalid[0]), 64'h1);
        check("s28_err", 64'(a_err[0]), 64'h1);
        check("s28_rdata", 64'(a_rdata[0]), 64'h0);
        drive(1, 1, 8'h12, 4'hF, 32'h1234_5678, 0, 8'h0); tick();
        check("s28_wr_err", 64'(a_err[0]), 64'h1);
        drive(1, 0, 8'h10, 4'h0, 32'h0, 0, 8'h0); tick();
        check("s28_unchanged", 64'(a_rdata[0]), 64'hDEAD_BEAA);

        // zero-strobe write still answers
        drive(1, 1, 8'h10, 4'h0, 32'hFFFF_FFFF, 0, 8'h0); tick();
        check("s13_nop_rsp", 64'(a_rvalid[0]), 64'h1);

        // same-edge collision: d0 read-first, d1 write-first
        drive(1, 1, 8'h20, 4'hF, 32'h1111_1111, 1, 8'h20); tick();
        check("s29_rf", 64'(b_rdata[0]), 64'h0);
        idle(2);
        check("s29_wf_vld", 64'(b_rvalid[1]), 64'h1);
        check("s29_wf", 64'(b_rdata[1]), 64'h1111_1111);
        idle(2);

        // back-to-back B reads on the latency-3 build
        drive(1, 1, 8'h00, 4'hF, 32'hA0, 0, 8'h0); tick();
        drive(1, 1, 8'h04, 4'hF, 32'hA4, 0, 8'h0); tick();
        drive(1, 1, 8'h08, 4'hF, 32'hA8, 0, 8'h0); tick();
        idle(3);
        for (int t = 0; t < 6; t++) begin
            if (t < 3) drive(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'(t * 4));
            else       drive(0, 0, 8'h0, 4'h0, 32'h0, 0, 8'h0);
            tick();
            vpat[t] = b_rvalid[1];
            if (t >= 2 && t <= 4)
                check($sformatf("s30_data%0d", t - 2), 64'(b_rdata[1]), 64'(32'hA0 + 32'((t - 2) * 4)));
        end
        check("s30_pattern", 64'(vpat), 64'b011100);

        // reset lands while two reads are in flight
        drive(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h00); tick();
        drive(0, 0, 8'h0, 4'h0, 32'h0, 1, 8'h04); tick();
        rst = 1'b1;
        drive(1, 1, 8'h00, 4'hF, 32'h5555_5555, 1, 8'h08);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("s31_rvalid", 64'(b_rvalid[1]), 64'h0);
            check("s31_rdata", 64'(b_rdata[1]), 64'h0);
            check("s31_ready", 64'({a_ready[1], b_ready[1]}), 64'h0);
        end
        rst = 1'b0;
        idle(4);
        drive(1, 0, 8'h00, 4'h0, 32'h0, 0, 8'h0); tick();
        check("s25_keep", 64'(a_rdata[0]), 64'hA0);
        idle(3);

        // random traffic with occasional reset
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                  8'($urandom_range(0, 255)) & (($urandom_range(0, 7) == 0) ? 8'hFF : 8'h3C),
                  4'($urandom_range(0, 15)), $urandom(),
                  $urandom_range(0, 3) != 0,
                  8'($urandom_range(0, 255)) & (($urandom_range(0, 7) == 0) ? 8'hFF : 8'h3C));
            tick();
        end
        rst = 1'b0;
        idle(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
